// File: rtl/life_gen_scheduler_pkg.sv
// Shared types and sizing for the Game-of-Life generation scheduler.
package life_pkg;

  localparam int unsigned LIFE_ADDR_W = 6;
  localparam int unsigned CELLS       = 2 ** LIFE_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    EVAL = 2'd2
  } phase_t;

endpackage

// File: rtl/life_gen_scheduler_if.sv
// Control bundle between the video timing side (master) and the
// generation scheduler (slave).
interface life_gen_scheduler_if #(
  parameter int unsigned ADDR_W = 6
);
  import life_pkg::*;

  logic              vblank_start;
  logic              run;
  logic              step;
  phase_t            phase;
  logic [ADDR_W-1:0] cell_addr;
  logic              copy_we;
  logic [ADDR_W-1:0] wb_addr;
  logic              eval_we;
  logic              display_sel;
  logic              gen_done;
  logic              overrun;

  modport master (
    output vblank_start, run, step,
    input  phase, cell_addr, copy_we, wb_addr, eval_we,
           display_sel, gen_done, overrun
  );

  modport slave (
    input  vblank_start, run, step,
    output phase, cell_addr, copy_we, wb_addr, eval_we,
           display_sel, gen_done, overrun
  );

endinterface

// File: rtl/life_gen_scheduler_frame_div.sv
// Frame divider: counts enabled ticks and fires on the FRAME_DIV-th one.
module life_frame_div #(
  parameter int unsigned FRAME_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic clear,
  output logic fire
);

  logic [7:0] count;

  assign fire = tick && enable && (count == 8'(FRAME_DIV - 1));

  // Tick counter; clear dominates, wraps to zero on fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && enable) begin
      count <= fire ? '0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/life_gen_scheduler.sv
// Generation scheduler: on an accepted vblank trigger, sweeps the board once
// copying curr->prev, then once evaluating cells with a one-cycle writeback lag.
// Optional feature macro: LIFE_SINGLE_STEP_EN (single-step while paused).
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 4,
  parameter int unsigned ADDR_W    = LIFE_ADDR_W
) (
  input logic                 clk,
  input logic                 reset,
  life_gen_scheduler_if.slave bus
);

  // ST_TAIL is the final EVAL cycle that only retires the last writeback.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_EVAL,
    ST_TAIL
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  phase_t            phase_q;
  logic [ADDR_W-1:0] cell_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              copy_we_q;
  logic              eval_we_q;
  logic              display_sel_q;
  logic              gen_done_q;
  logic              overrun_q;

  logic accept;
  logic fire;
  logic trig;

  assign accept = bus.vblank_start && (state == ST_IDLE);

  life_frame_div #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_div (
    .clk   (clk),
    .reset (reset),
    .tick  (accept),
    .enable(bus.run),
    .clear (!bus.run),
    .fire  (fire)
  );

`ifdef LIFE_SINGLE_STEP_EN
  logic step_pending;

  assign trig = accept && (fire || step_pending);

  // Latch a step request while paused; consumed by the next accepted trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_pending <= 1'b0;
    end else if (trig) begin
      step_pending <= 1'b0;
    end else if (bus.step && !bus.run) begin
      step_pending <= 1'b1;
    end
  end
`else
  assign trig = accept && fire;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase_q       <= IDLE;
      cell_addr_q   <= '0;
      wb_addr_q     <= '0;
      copy_we_q     <= 1'b0;
      eval_we_q     <= 1'b0;
      display_sel_q <= 1'b0;
      gen_done_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      if (bus.vblank_start && (state != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (trig) begin
            state       <= ST_COPY;
            phase_q     <= COPY;
            cell_addr_q <= '0;
            copy_we_q   <= 1'b1;
          end
        end
        ST_COPY: begin
          cell_addr_q <= cell_addr_q + ADDR_W'(1);
          if (cell_addr_q == LAST_ADDR) begin
            state         <= ST_EVAL;
            phase_q       <= EVAL;
            copy_we_q     <= 1'b0;
            display_sel_q <= 1'b1;
          end
        end
        ST_EVAL: begin
          cell_addr_q <= cell_addr_q + ADDR_W'(1);
          wb_addr_q   <= cell_addr_q;
          eval_we_q   <= 1'b1;
          if (cell_addr_q == LAST_ADDR) begin
            state <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          state         <= ST_IDLE;
          phase_q       <= IDLE;
          wb_addr_q     <= '0;
          eval_we_q     <= 1'b0;
          display_sel_q <= 1'b0;
          gen_done_q    <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.phase       = phase_q;
  assign bus.cell_addr   = cell_addr_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.copy_we     = copy_we_q;
  assign bus.eval_we     = eval_we_q;
  assign bus.display_sel = display_sel_q;
  assign bus.gen_done    = gen_done_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Testbench for life_gen_scheduler: directed scenarios plus random traffic,
// checked every cycle against a timeline model of a generation.
module tb_life_gen_scheduler;
  import life_pkg::*;

  localparam int FDIV = 4;
  localparam int AW   = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_gen_scheduler_if #(.ADDR_W(AW)) bus();

  life_gen_scheduler #(
    .FRAME_DIV(FDIV),
    .ADDR_W   (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int gen_seen = 0;

  // Reference model: cycle index, start cycle of the latest generation.
  int cyc       = 0;
  int gen_start = -100000;
  int div_cnt   = 0;
  bit pend      = 1'b0;
  bit ovr       = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit busy(input int c);
    int k;
    k = c - gen_start;
    return (k >= 1) && (k <= 129);
  endfunction

  task automatic model_rst();
    gen_start = -100000;
    div_cnt   = 0;
    pend      = 1'b0;
    ovr       = 1'b0;
  endtask

  // Apply the rules for the cycle that just ended at this clock edge.
  task automatic model_edge();
    bit start;
    start = 1'b0;
    if (reset) begin
      model_rst();
    end else begin
      if (bus.vblank_start && busy(cyc)) ovr = 1'b1;
      if (bus.vblank_start && !busy(cyc)) begin
        if (bus.run) begin
          div_cnt++;
          if (div_cnt == FDIV) begin
            div_cnt = 0;
            start   = 1'b1;
          end
        end
`ifdef LIFE_SINGLE_STEP_EN
        if (pend) start = 1'b1;
`endif
      end
      if (!bus.run) div_cnt = 0;
`ifdef LIFE_SINGLE_STEP_EN
      if (start) pend = 1'b0;
      else if (bus.step && !bus.run) pend = 1'b1;
`endif
      if (start) gen_start = cyc;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    int k;
    int e_ph, e_ca, e_cw, e_wb, e_ew, e_ds, e_gd;
    k    = cyc - gen_start;
    e_ph = (k >= 1 && k <= 64) ? 1 : (k >= 65 && k <= 129) ? 2 : 0;
    e_ca = (k >= 1 && k <= 64) ? k - 1 : (k >= 65 && k <= 128) ? k - 65 : 0;
    e_cw = (k >= 1 && k <= 64) ? 1 : 0;
    e_ew = (k >= 66 && k <= 129) ? 1 : 0;
    e_wb = (k >= 66 && k <= 129) ? k - 66 : 0;
    e_ds = (k >= 65 && k <= 129) ? 1 : 0;
    e_gd = (k == 130) ? 1 : 0;
    check("phase", bus.phase, e_ph);
    check("cell_addr", bus.cell_addr, e_ca);
    check("copy_we", bus.copy_we, e_cw);
    check("eval_we", bus.eval_we, e_ew);
    check("wb_addr", bus.wb_addr, e_wb);
    check("display_sel", bus.display_sel, e_ds);
    check("gen_done", bus.gen_done, e_gd);
    check("overrun", bus.overrun, int'(ovr));
    check("we_exclusive", bus.copy_we & bus.eval_we, 0);
    if (bus.gen_done === 1'b1) gen_seen++;
  endtask

  task automatic tick_cycle(input bit vb, input bit rn, input bit st);
    bus.vblank_start = vb;
    bus.run          = rn;
    bus.step         = st;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Assert reset between edges, confirm outputs clear immediately, hold, release.
  task automatic reset_pulse(input int hold, input bit rn);
    #2;
    reset = 1'b1;
    model_rst();
    #1;
    check_outputs();
    repeat (hold) tick_cycle(1'b0, rn, 1'b0);
    #2;
    reset = 1'b0;
  endtask

  task automatic run_trigger(input int gap);
    for (int p = 0; p < FDIV; p++) begin
      tick_cycle(1'b1, 1'b1, 1'b0);
      repeat (gap) tick_cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int base;
    bit rn;
    bus.vblank_start = 1'b0;
    bus.run          = 1'b0;
    bus.step         = 1'b0;
    reset            = 1'b1;

    // Reset state
    repeat (3) tick_cycle(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;

    // Divider: generation only after the FRAME_DIV-th pulse
    base = gen_seen;
    run_trigger(5);
    repeat (140) tick_cycle(1'b0, 1'b1, 1'b0);
    check("gens_div", gen_seen - base, 1);

    // vblank injected at T+50 while busy: ignored, sticky overrun
    base = gen_seen;
    run_trigger(1);
    repeat (49 - 1) tick_cycle(1'b0, 1'b1, 1'b0);
    tick_cycle(1'b1, 1'b1, 1'b0);
    repeat (100) tick_cycle(1'b0, 1'b1, 1'b0);
    check("gens_overrun", gen_seen - base, 1);
    check("overrun_sticky", bus.overrun, 1);

    // Reset at T+80 (mid-EVAL): no resumption, no gen_done
    run_trigger(0);
    repeat (79) tick_cycle(1'b0, 1'b1, 1'b0);
    base = gen_seen;
    reset_pulse(2, 1'b0);
    repeat (200) tick_cycle(1'b0, 1'b0, 1'b0);
    check("gens_after_reset", gen_seen - base, 0);

    // Paused, no step: 10 vblanks do nothing
    base = gen_seen;
    for (int i = 0; i < 10; i++) begin
      tick_cycle(1'b1, 1'b0, 1'b0);
      repeat (3) tick_cycle(1'b0, 1'b0, 1'b0);
    end
    check("gens_paused", gen_seen - base, 0);

    // Single step (or ignored step when the feature is absent)
    base = gen_seen;
    tick_cycle(1'b0, 1'b0, 1'b1);
    repeat (3) tick_cycle(1'b0, 1'b0, 1'b0);
    tick_cycle(1'b1, 1'b0, 1'b0);
    repeat (140) tick_cycle(1'b0, 1'b0, 1'b0);
    tick_cycle(1'b1, 1'b0, 1'b0);
    repeat (140) tick_cycle(1'b0, 1'b0, 1'b0);
`ifdef LIFE_SINGLE_STEP_EN
    check("gens_step", gen_seen - base, 1);
`else
    check("gens_step", gen_seen - base, 0);
`endif

    // Random traffic
    rn = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(199) == 0) rn = ~rn;
      if ($urandom_range(1499) == 0) begin
        reset_pulse(2, rn);
      end else begin
        tick_cycle($urandom_range(14) == 0, rn, $urandom_range(29) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
